// File: rtl/mips_muldiv_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Multiplies use radix-2 shift-add and divides use radix-2 restoring division.
// Both operate on magnitudes, and a sign fix-up is applied on entry to the finish state.
// Optional build macro MUL_FAST_EN: MULT/MULTU produce a single-cycle combinational product.
// That path goes straight from idle to the finish state. Divides are unaffected.
module mips_muldiv_unit #(
  parameter int unsigned ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned CntW = $clog2(ITER);

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  // Mul: {partial upper, remaining multiplier}. Div: {partial remainder, dividend/quotient}.
  logic [63:0]     acc_q, acc_d;
  // Mul: multiplicand magnitude. Div: divisor magnitude.
  logic [31:0]     opb_q, opb_d;
  logic            is_div_q, is_div_d;
  logic            neg_main_q, neg_main_d;   // negate product / quotient
  logic            neg_rem_q, neg_rem_d;     // negate remainder (dividend was negative)
  logic            div_zero_q, div_zero_d;
  logic [31:0]     raw_a_q, raw_a_d;         // unmodified rs, reported in HI on divide by zero
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;

  // Operand conditioning for a command presented this cycle.
  logic        signed_op;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;

  // One iteration of each algorithm from the current partial state.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift, div_diff;
  logic        div_ge;
  logic [63:0] div_next;
  logic [63:0] step_next;

  // Signed-corrected result of the final iteration.
  logic [31:0] q_mag, r_mag;
  logic [63:0] mul_fix;
  logic [31:0] fix_hi, fix_lo;

`ifdef MUL_FAST_EN
  logic [63:0] ext_a, ext_b, fast_prod;
`endif

  // Sign handling and magnitude extraction of incoming operands.
  always_comb begin
    signed_op = ~op[0];
    a_neg     = signed_op & rs_val[31];
    b_neg     = signed_op & rt_val[31];
    // 0x80000000 negates to itself, which reads correctly as unsigned 2^31.
    a_mag     = a_neg ? (32'd0 - rs_val) : rs_val;
    b_mag     = b_neg ? (32'd0 - rt_val) : rt_val;
  end

`ifdef MUL_FAST_EN
  // Single-cycle product; low 64 bits of a sign-extended multiply are exact for both forms.
  always_comb begin
    ext_a     = {{32{a_neg}}, rs_val};
    ext_b     = {{32{b_neg}}, rt_val};
    fast_prod = ext_a * ext_b;
  end
`endif

  // Single radix-2 multiply and divide steps, plus final sign fix-up.
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    mul_next  = {mul_sum, acc_q[31:1]};

    // Remainder is always below the divisor, so a 33-bit difference sign is exact.
    div_shift = {acc_q[63:32], acc_q[31]};
    div_diff  = div_shift - {1'b0, opb_q};
    div_ge    = ~div_diff[32];
    div_next  = {(div_ge ? div_diff[31:0] : div_shift[31:0]), acc_q[30:0], div_ge};

    step_next = is_div_q ? div_next : mul_next;

    q_mag     = step_next[31:0];
    r_mag     = step_next[63:32];
    mul_fix   = neg_main_q ? (64'd0 - step_next) : step_next;

    if (!is_div_q) begin
      fix_hi = mul_fix[63:32];
      fix_lo = mul_fix[31:0];
    end else if (div_zero_q) begin
      fix_hi = raw_a_q;
      fix_lo = 32'hFFFF_FFFF;
    end else begin
      fix_hi = neg_rem_q  ? (32'd0 - r_mag) : r_mag;
      fix_lo = neg_main_q ? (32'd0 - q_mag) : q_mag;
    end
  end

  // Next-state logic: command acceptance in IDLE/FIN, iteration in RUN.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opb_d      = opb_q;
    is_div_d   = is_div_q;
    neg_main_d = neg_main_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    raw_a_d    = raw_a_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    unique case (state_q)
      StRun: begin
        acc_d = step_next;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(ITER - 1)) begin
          state_d = StFin;
          hi_d    = fix_hi;
          lo_d    = fix_lo;
        end
      end
      StIdle, StFin: begin
        state_d = StIdle;
        if (start) begin
          case (op)
            OpMthi: hi_d = rs_val;
            OpMtlo: lo_d = rs_val;
            OpMult, OpMultu: begin
`ifdef MUL_FAST_EN
              state_d = StFin;
              hi_d    = fast_prod[63:32];
              lo_d    = fast_prod[31:0];
`else
              state_d    = StRun;
              cnt_d      = '0;
              acc_d      = {32'd0, b_mag};
              opb_d      = a_mag;
              is_div_d   = 1'b0;
              neg_main_d = a_neg ^ b_neg;
              neg_rem_d  = 1'b0;
              div_zero_d = 1'b0;
              raw_a_d    = rs_val;
`endif
            end
            OpDiv, OpDivu: begin
              state_d    = StRun;
              cnt_d      = '0;
              acc_d      = {32'd0, a_mag};
              opb_d      = b_mag;
              is_div_d   = 1'b1;
              neg_main_d = a_neg ^ b_neg;
              neg_rem_d  = a_neg;
              div_zero_d = (rt_val == 32'd0);
              raw_a_d    = rs_val;
            end
            default: ;  // reserved encodings are no-ops
          endcase
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; everything freezes while clk_enable is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      opb_q      <= '0;
      is_div_q   <= 1'b0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      raw_a_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else if (clk_enable) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opb_q      <= opb_d;
      is_div_q   <= is_div_d;
      neg_main_q <= neg_main_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      raw_a_q    <= raw_a_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  // Status outputs are pure state decodes so they freeze with the FSM.
  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StFin);
    hi   = hi_q;
    lo   = lo_q;
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: directed corner cases plus randomized commands
// checked against an arithmetic reference model of HI/LO.
module tb_mips_muldiv_unit;

  localparam int ITER = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_hi, exp_lo;

  mips_muldiv_unit #(.ITER(ITER)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .start      (start),
    .op         (op),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference results straight from integer arithmetic on the architectural operands.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    eh = exp_hi;
    el = exp_lo;
    case (o)
      3'd0: begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; eh = p[63:32]; el = p[31:0]; end
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          eh = a;
          el = 32'hFFFF_FFFF;
        end else if (o == 3'd2) begin
          q = sa / sb;
          r = sa % sb;
          eh = r[31:0];
          el = q[31:0];
        end else begin
          eh = a % b;
          el = a / b;
        end
      end
      3'd4: eh = a;
      3'd5: el = a;
      default: ;
    endcase
  endtask

  function automatic int exp_edges(input logic [2:0] o);
`ifdef MUL_FAST_EN
    if (!o[1]) return 1;
`endif
    return ITER + 1;
  endfunction

  // Present a command for one enabled edge, then scramble operands to prove they were latched.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    tick();
    start  = 1'b0;
    rs_val = $urandom;
    rt_val = $urandom;
  endtask

  // Counts edges since acceptance until done; HI/LO must hold the old model values meanwhile.
  task automatic wait_done(input int n0, output int n, output int nb);
    logic held;
    held = 1'b1;
    n    = n0;
    nb   = 0;
    while (!done && n < 200) begin
      if (busy) nb++;
      if (hi !== exp_hi || lo !== exp_lo) held = 1'b0;
      tick();
      if (clk_enable) n++;
    end
    check("hold_during_run", 64'(held), 64'd1);
    check("done_seen", 64'(done), 64'd1);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    int n, nb;
    model(o, a, b, eh, el);
    issue(o, a, b);
    wait_done(1, n, nb);
    check("latency", 64'(n), 64'(exp_edges(o)));
    check("busy_cycles", 64'(nb), 64'(exp_edges(o) - 1));
    check("hi", 64'(hi), 64'(eh));
    check("lo", 64'(lo), 64'(el));
    exp_hi = eh;
    exp_lo = el;
    tick();
    check("done_single_pulse", 64'(done), 64'd0);
  endtask

  // MTHI/MTLO and reserved encodings complete on the accept edge with no busy.
  task automatic simple_op(input logic [2:0] o, input logic [31:0] a);
    logic [31:0] eh, el;
    model(o, a, 32'd0, eh, el);
    issue(o, a, 32'd0);
    check("simple_busy", 64'(busy), 64'd0);
    check("simple_hi", 64'(hi), 64'(eh));
    check("simple_lo", 64'(lo), 64'(el));
    exp_hi = eh;
    exp_lo = el;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'(($urandom_range(0, 20)));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] eh, el;
    int n, nb;
    reset = 1'b1; clk_enable = 1'b1; start = 1'b0; op = 3'd0; rs_val = '0; rt_val = '0;
    exp_hi = '0; exp_lo = '0;
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    tick();

    // Directed arithmetic corners.
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd0, 32'hFFFF_FFFE, 32'd3);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd3, 32'd100, 32'd7);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd3, 32'h55, 32'd0);
    run_op(3'd2, 32'hFFFF_FFF0, 32'd0);
    run_op(3'd0, 32'h8000_0000, 32'h8000_0000);

    // Asynchronous reset after 10 RUN cycles of a divide.
    issue(3'd3, 32'd12345, 32'd17);
    repeat (10) tick();
    #2 reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    tick();
    simple_op(3'd5, 32'h1234);

    // MTHI while busy must be dropped.
    model(3'd3, 32'd100, 32'd7, eh, el);
    issue(3'd3, 32'd100, 32'd7);
    issue(3'd4, 32'hAAAA, 32'd0);
    wait_done(2, n, nb);
    check("mthi_busy_hi", 64'(hi), 64'(eh));
    check("mthi_busy_lo", 64'(lo), 64'(el));
    exp_hi = eh; exp_lo = el;

    // Start presented in the FIN cycle is accepted.
    issue(3'd1, 32'd6, 32'd7);
`ifdef MUL_FAST_EN
    check("fin_accept_done", 64'(done), 64'd1);
    n = 1;
`else
    check("fin_accept_busy", 64'(busy), 64'd1);
    wait_done(1, n, nb);
`endif
    check("fin_accept_latency", 64'(n), 64'(exp_edges(3'd1)));
    check("fin_accept_lo", 64'(lo), 64'd42);
    check("fin_accept_hi", 64'(hi), 64'd0);
    exp_hi = 32'd0; exp_lo = 32'd42;
    tick();

    // Five disabled cycles mid-RUN shift completion by exactly five cycles.
    model(3'd2, 32'hFFFF_F000, 32'd13, eh, el);
    issue(3'd2, 32'hFFFF_F000, 32'd13);
    repeat (10) tick();
    clk_enable = 1'b0;
    repeat (5) tick();
    check("stall_busy_frozen", 64'(busy), 64'd1);
    clk_enable = 1'b1;
    n = 11;
    while (!done && n < 200) begin tick(); n++; end
    check("stall_latency", 64'(n), 64'(ITER + 1));
    check("stall_hi", 64'(hi), 64'(eh));
    check("stall_lo", 64'(lo), 64'(el));
    exp_hi = eh; exp_lo = el;
    clk_enable = 1'b0;
    repeat (3) tick();
    check("stall_done_frozen", 64'(done), 64'd1);
    clk_enable = 1'b1;
    tick();

    // Randomized command mix.
    for (int i = 0; i < 60; i++) begin
      int k;
      k = $urandom_range(0, 9);
      if (k < 4)       run_op(3'(k), pick_operand(), pick_operand());
      else if (k < 6)  simple_op(3'(k), $urandom);
      else if (k < 8)  simple_op(3'(k - 2), $urandom);
      else             simple_op(3'(k - 2), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
